spi_slave_core: RTL and testbench

SPI responder (slave) shift engine. It is the far end of the SPI master built around the spi_clkgen serial clock.
- Oversamples the external sclk, ss_n and mosi in the wb_clk domain.
- Shifts received bits into a word and returns a transmit word on miso.
- Exposes a one-entry TX holding buffer (valid/ready) and a one-cycle RX strobe to local logic.

---
 rtl/spi_slave_core.sv | 200 ++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI responder shift engine: oversampled sclk/ss_n/mosi, one-entry TX holding buffer, RX word strobe.
// Optional SPI_SLAVE_UNDERRUN_EN adds a sticky underrun flag with clear input.
module spi_slave_core #(
    parameter int CHAR_LEN    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                wb_clk,
    input  logic                wb_rst,
    input  logic                sclk_in,
    input  logic                ss_n,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsb,
    input  logic [CHAR_LEN-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [CHAR_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                busy
`ifdef SPI_SLAVE_UNDERRUN_EN
    ,
    output logic                underrun,
    input  logic                underrun_clr
`endif
);

    localparam int CNT_W = (CHAR_LEN > 2) ? $clog2(CHAR_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAR_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sclk_pipe, ss_pipe, mosi_pipe;
    logic sclk_s, ss_n_s, mosi_s;
    logic sclk_d, ss_n_d;
    logic cpol_l, cpha_l, lsb_l;

    logic [CHAR_LEN-1:0] hold_q;
    logic                hold_full;
    logic [CHAR_LEN-1:0] tx_shift, tx_adv, load_word;
    logic [CHAR_LEN-1:0] rx_shift, rx_next;
    logic [CNT_W-1:0]    bit_cnt;
    logic                first_shift, load_pend;

    logic sclk_edge, lead_e, trail_e, sample_e, shift_e;
    logic in_shift, word_done, do_load, do_advance, hs;

    // Sync chains reset to 0 so a select held low across reset never looks like a fresh fall.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            sclk_pipe <= '0;
            ss_pipe   <= '0;
            mosi_pipe <= '0;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk_in};
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], ss_n};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
        end
    end

    assign sclk_s = sclk_pipe[SYNC_STAGES-1];
    assign ss_n_s = ss_pipe[SYNC_STAGES-1];
    assign mosi_s = mosi_pipe[SYNC_STAGES-1];

    function automatic logic head_bit(input logic [CHAR_LEN-1:0] w, input logic lsb_first);
        return lsb_first ? w[0] : w[CHAR_LEN-1];
    endfunction

    assign sclk_edge = sclk_s ^ sclk_d;
    assign lead_e    = sclk_edge && (sclk_s != cpol_l);
    assign trail_e   = sclk_edge && (sclk_s == cpol_l);
    assign sample_e  = cpha_l ? trail_e : lead_e;
    assign shift_e   = cpha_l ? lead_e : trail_e;

    assign in_shift   = (state == S_SHIFT) && !ss_n_s;
    assign word_done  = in_shift && sample_e && (bit_cnt == LAST_BIT);
    assign do_load    = ((state == S_LOAD) && !ss_n_s) || (word_done && cpha_l)
                        || (in_shift && shift_e && load_pend);
    assign do_advance = in_shift && shift_e && !load_pend && !(cpha_l && first_shift);
    assign hs         = tx_valid && !hold_full;
    assign load_word  = hold_full ? hold_q : '0;
    assign tx_adv     = lsb_l ? (tx_shift >> 1) : (tx_shift << 1);
    assign rx_next    = lsb_l ? {mosi_s, rx_shift[CHAR_LEN-1:1]}
                              : {rx_shift[CHAR_LEN-2:0], mosi_s};

    assign tx_ready = !hold_full;
    assign miso_oe  = busy;

    // A handshake coinciding with a load refills the holding register just emptied.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            hold_full <= 1'b0;
            hold_q    <= '0;
        end else begin
            if (hs)
                hold_q <= tx_data;
            hold_full <= do_load ? hs : (hold_full | hs);
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state       <= S_IDLE;
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            lsb_l       <= 1'b0;
            sclk_d      <= 1'b0;
            ss_n_d      <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            first_shift <= 1'b0;
            load_pend   <= 1'b0;
            miso        <= 1'b0;
            busy        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
        end else begin
            sclk_d   <= sclk_s;
            ss_n_d   <= ss_n_s;
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!ss_n_s && ss_n_d) begin
                        cpol_l <= cpol;
                        cpha_l <= cpha;
                        lsb_l  <= lsb;
                        busy   <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ss_n_s) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        bit_cnt   <= '0;
                        rx_shift  <= '0;
                        load_pend <= 1'b0;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ss_n_s) begin
                        busy      <= 1'b0;
                        load_pend <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        if (sample_e) begin
                            if (bit_cnt == LAST_BIT) begin
                                rx_data   <= rx_next;
                                rx_valid  <= 1'b1;
                                rx_shift  <= '0;
                                bit_cnt   <= '0;
                                load_pend <= !cpha_l;
                            end else begin
                                rx_shift <= rx_next;
                                bit_cnt  <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (shift_e) begin
                            first_shift <= 1'b0;
                            load_pend   <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Load takes priority over advance; it re-arms the cpha=1 first-edge skip.
            if (do_load) begin
                tx_shift    <= load_word;
                miso        <= head_bit(load_word, lsb_l);
                first_shift <= 1'b1;
            end else if (do_advance) begin
                tx_shift <= tx_adv;
                miso     <= head_bit(tx_adv, lsb_l);
            end
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    always_ff @(posedge wb_clk) begin
        if (wb_rst)
            underrun <= 1'b0;
        else if (do_load && !hold_full)
            underrun <= 1'b1;
        else if (underrun_clr)
            underrun <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: acts as SPI master in modes 0 and 3, checks words, strobes and aborts.
module tb_spi_slave_core;
    localparam int H = 6;

    logic       wb_clk = 1'b0;
    logic       wb_rst;
    logic       sclk_in, ss_n, mosi, miso, miso_oe;
    logic       cpol, cpha, lsb;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, busy;
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic       underrun, underrun_clr;
`endif

    int         total = 0;
    int         bad = 0;
    logic [7:0] rx_q[$];
    logic [7:0] m1, m2;
    int         r0;

    spi_slave_core #(.CHAR_LEN(8), .SYNC_STAGES(2)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .sclk_in(sclk_in), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .lsb(lsb),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_UNDERRUN_EN
        , .underrun(underrun), .underrun_clr(underrun_clr)
`endif
    );

    always #5 wb_clk = ~wb_clk;

    always @(negedge wb_clk)
        if (rx_valid === 1'b1) rx_q.push_back(rx_data);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            clks(1);
            n++;
        end
        if (n >= 200) check_val("push_timeout", {31'b0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        clks(1);
        tx_valid = 1'b0;
    endtask

    // Master side: drives mosi/sclk for nbits, captures miso at its sample edge.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        int idx;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : 7 - i;
            if (!cpha) begin
                mosi = mo[idx];
                clks(H);
                mi[idx] = miso;
                sclk_in = ~cpol;
                clks(H);
                sclk_in = cpol;
            end else begin
                clks(H);
                sclk_in = ~cpol;
                mosi = mo[idx];
                clks(H);
                mi[idx] = miso;
                sclk_in = cpol;
            end
        end
    endtask

    initial begin
        wb_rst = 1'b1; sclk_in = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; tx_data = '0; tx_valid = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
        underrun_clr = 1'b0;
`endif
        clks(3);
        wb_rst = 1'b0;
        check_val("rst_miso", {31'b0, miso}, 0);
        check_val("rst_oe", {31'b0, miso_oe}, 0);
        check_val("rst_busy", {31'b0, busy}, 0);
        check_val("rst_rxv", {31'b0, rx_valid}, 0);
        check_val("rst_rxd", {24'b0, rx_data}, 0);
        check_val("rst_txr", {31'b0, tx_ready}, 1);
`ifdef SPI_SLAVE_UNDERRUN_EN
        check_val("rst_unr", {31'b0, underrun}, 0);
`endif

        // Mode 0, MSB first
        push(8'hA5);
        check_val("m0_hold_full", {31'b0, tx_ready}, 0);
        ss_n = 1'b0;
        clks(8);
        check_val("m0_txr_after_load", {31'b0, tx_ready}, 1);
        check_val("m0_busy", {31'b0, busy}, 1);
        check_val("m0_oe", {31'b0, miso_oe}, 1);
        check_val("m0_first_bit", {31'b0, miso}, 1);
        r0 = rx_q.size();
        xfer(8'h3C, 8, m1);
        check_val("m0_miso_word", {24'b0, m1}, 32'hA5);
        clks(8);
        check_val("m0_rx_pulses", rx_q.size() - r0, 1);
        check_val("m0_rx_data", {24'b0, rx_data}, 32'h3C);
        ss_n = 1'b1;
        clks(8);
        check_val("m0_busy_off", {31'b0, busy}, 0);

        // Mode 3, LSB first
        cpol = 1'b1; cpha = 1'b1; lsb = 1'b1; sclk_in = 1'b1;
        clks(4);
        push(8'h81);
        ss_n = 1'b0;
        clks(8);
        r0 = rx_q.size();
        xfer(8'h0F, 8, m1);
        check_val("m3_miso_word", {24'b0, m1}, 32'h81);
        clks(8);
        check_val("m3_rx_pulses", rx_q.size() - r0, 1);
        check_val("m3_rx_data", {24'b0, rx_data}, 32'h0F);
        ss_n = 1'b1;
        clks(8);

        // Two back-to-back words, second TX word pushed during the first
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; sclk_in = 1'b0;
        clks(4);
        push(8'h11);
        ss_n = 1'b0;
        clks(8);
        r0 = rx_q.size();
        fork
            xfer(8'hDE, 8, m1);
            begin clks(30); push(8'h22); end
        join
        xfer(8'hAD, 8, m2);
        clks(8);
        check_val("c2_miso_w1", {24'b0, m1}, 32'h11);
        check_val("c2_miso_w2", {24'b0, m2}, 32'h22);
        check_val("c2_rx_pulses", rx_q.size() - r0, 2);
        check_val("c2_rx_w1", {24'b0, rx_q[r0]}, 32'hDE);
        check_val("c2_rx_w2", {24'b0, rx_q[r0+1]}, 32'hAD);
        ss_n = 1'b1;
        clks(8);

        // Abort after 5 clocks, then a clean transfer
        push(8'h55);
        ss_n = 1'b0;
        clks(8);
        push(8'h66);
        r0 = rx_q.size();
        xfer(8'hFF, 5, m1);
        clks(8);
        ss_n = 1'b1;
        clks(8);
        check_val("ab_busy", {31'b0, busy}, 0);
        check_val("ab_oe", {31'b0, miso_oe}, 0);
        check_val("ab_miso_hold", {31'b0, miso}, 1);
        check_val("ab_no_rxv", rx_q.size() - r0, 0);
        ss_n = 1'b0;
        clks(8);
        xfer(8'h12, 8, m1);
        clks(8);
        check_val("ab_next_word", {24'b0, m1}, 32'h66);
        check_val("ab_next_rx_pulses", rx_q.size() - r0, 1);
        check_val("ab_next_rx", {24'b0, rx_data}, 32'h12);
        ss_n = 1'b1;
        clks(8);

        // Underrun: nothing pushed
`ifdef SPI_SLAVE_UNDERRUN_EN
        underrun_clr = 1'b1;
        clks(1);
        underrun_clr = 1'b0;
        check_val("ur_cleared_pre", {31'b0, underrun}, 0);
`endif
        ss_n = 1'b0;
        clks(8);
        xfer(8'hC3, 8, m1);
        clks(8);
        check_val("ur_zeros", {24'b0, m1}, 0);
        check_val("ur_rx", {24'b0, rx_data}, 32'hC3);
        ss_n = 1'b1;
        clks(8);
`ifdef SPI_SLAVE_UNDERRUN_EN
        check_val("ur_sticky", {31'b0, underrun}, 1);
        underrun_clr = 1'b1;
        clks(1);
        underrun_clr = 1'b0;
        check_val("ur_clr", {31'b0, underrun}, 0);
`endif

        // Reset at bit 3 with a word still waiting in holding
        push(8'h77);
        ss_n = 1'b0;
        clks(8);
        push(8'h88);
        xfer(8'hA5, 3, m1);
        wb_rst = 1'b1;
        clks(1);
        wb_rst = 1'b0;
        check_val("mr_miso", {31'b0, miso}, 0);
        check_val("mr_oe", {31'b0, miso_oe}, 0);
        check_val("mr_busy", {31'b0, busy}, 0);
        check_val("mr_rxv", {31'b0, rx_valid}, 0);
        check_val("mr_rxd", {24'b0, rx_data}, 0);
        check_val("mr_txr", {31'b0, tx_ready}, 1);
        r0 = rx_q.size();
        xfer(8'hA5, 5, m1);
        clks(8);
        check_val("mr_ignore_busy", {31'b0, busy}, 0);
        check_val("mr_ignore_rx", rx_q.size() - r0, 0);
        ss_n = 1'b1;
        clks(8);
        push(8'h99);
        ss_n = 1'b0;
        clks(8);
        xfer(8'h5A, 8, m1);
        clks(8);
        check_val("mr_after_word", {24'b0, m1}, 32'h99);
        check_val("mr_after_rx", {24'b0, rx_data}, 32'h5A);
        ss_n = 1'b1;
        clks(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
